// File: rtl/noc_pkg.sv
// Shared flit layout, widths and helpers for the NoC leaf interface.
package noc_pkg;

  localparam int unsigned DATA_WIDTH    = 34;
  localparam int unsigned ADDR_WIDTH    = 2;
  localparam int unsigned PAYLOAD_WIDTH = DATA_WIDTH - ADDR_WIDTH;
  localparam int unsigned DEST_MSB      = DATA_WIDTH - 1;
  localparam int unsigned DEST_LSB      = DATA_WIDTH - ADDR_WIDTH;
  localparam int unsigned STAT_WIDTH    = 16;

  typedef logic [ADDR_WIDTH-1:0]    addr_t;
  typedef logic [PAYLOAD_WIDTH-1:0] payload_t;

  typedef struct packed {
    addr_t    dest;
    payload_t payload;
  } flit_t;

  function automatic flit_t flit_pack(input addr_t dest, input payload_t payload);
    flit_t f;
    f.dest    = dest;
    f.payload = payload;
    return f;
  endfunction

  function automatic addr_t flit_dest(input flit_t f);
    return f[DEST_MSB:DEST_LSB];
  endfunction

  function automatic payload_t flit_payload(input flit_t f);
    return f.payload;
  endfunction

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_WIDTH-1:0] stat_inc(input logic [STAT_WIDTH-1:0] v,
                                                     input logic en);
    return (en && (v != '1)) ? v + STAT_WIDTH'(1) : v;
  endfunction

endpackage

// File: rtl/noc_leaf_if_if.sv
// PE-side and switch-side handshake bundle of the NoC leaf interface.
interface noc_leaf_bus
  import noc_pkg::*;
#(
  parameter int unsigned DataWidth = DATA_WIDTH,
  parameter int unsigned AddrWidth = ADDR_WIDTH
);
  localparam int unsigned PayloadWidth = DataWidth - AddrWidth;

  logic [PayloadWidth-1:0] i_pe_data;
  logic [AddrWidth-1:0]    i_pe_dest;
  logic                    i_pe_data_valid;
  logic                    o_pe_data_ready;
  logic [PayloadWidth-1:0] o_pe_data;
  logic                    o_pe_src_valid;
  logic                    i_pe_data_ready;
  logic [DataWidth-1:0]    o_noc_data;
  logic                    o_noc_data_valid;
  logic                    i_noc_data_ready;
  logic [DataWidth-1:0]    i_noc_data;
  logic                    i_noc_data_valid;
  logic                    o_noc_data_ready;
  logic                    o_misroute;

  modport slave (
    input  i_pe_data, i_pe_dest, i_pe_data_valid, i_pe_data_ready,
           i_noc_data_ready, i_noc_data, i_noc_data_valid,
    output o_pe_data_ready, o_pe_data, o_pe_src_valid, o_noc_data,
           o_noc_data_valid, o_noc_data_ready, o_misroute
  );

  modport master (
    output i_pe_data, i_pe_dest, i_pe_data_valid, i_pe_data_ready,
           i_noc_data_ready, i_noc_data, i_noc_data_valid,
    input  o_pe_data_ready, o_pe_data, o_pe_src_valid, o_noc_data,
           o_noc_data_valid, o_noc_data_ready, o_misroute
  );

endinterface

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with registered count/full/empty; power-of-two depth, no fall-through.
module noc_sync_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CntW'(1);
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - CntW'(1);
    end
  end

  // Storage is cleared on reset so the head output reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == CntW'(Depth));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/noc_leaf_if.sv
// Leaf network interface: TX FIFO from PE to switch, address-checked 2-entry RX buffer to PE.
// Optional statistics counters are enabled with NOC_LEAF_IF_STATS_EN.
module noc_leaf_if
  import noc_pkg::*;
#(
  parameter int unsigned DataWidth = DATA_WIDTH,
  parameter int unsigned AddrWidth = ADDR_WIDTH,
  parameter int unsigned MyAddr    = 0,
  parameter int unsigned TxDepth   = 4
) (
  input logic        i_sclk,
  input logic        i_reset,
  noc_leaf_bus.slave bus
`ifdef NOC_LEAF_IF_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] o_tx_count,
  output logic [STAT_WIDTH-1:0] o_rx_count,
  output logic [STAT_WIDTH-1:0] o_drop_count
`endif
);
  localparam int unsigned PayloadWidth = DataWidth - AddrWidth;
  localparam int unsigned RxDepth      = 2;
  localparam int unsigned TxCntW       = $clog2(TxDepth + 1);
  localparam int unsigned RxCntW       = $clog2(RxDepth + 1);

  logic                    tx_push, tx_pop, tx_full, tx_empty;
  logic [TxCntW-1:0]       tx_count;
  logic [DataWidth-1:0]    tx_wdata, tx_rdata;

  logic                    rx_accept, rx_hit, rx_push, rx_pop, rx_full, rx_empty;
  logic [RxCntW-1:0]       rx_count;
  logic [PayloadWidth-1:0] rx_wdata, rx_rdata;
  logic                    misroute;
  logic                    unused_ok;

  // TX: readiness reflects registered FIFO state only, never the incoming valid.
  assign tx_push  = bus.i_pe_data_valid && !tx_full;
  assign tx_pop   = bus.i_noc_data_ready && !tx_empty;
  assign tx_wdata = flit_pack(bus.i_pe_dest, bus.i_pe_data);

  noc_sync_fifo #(.Depth(TxDepth), .Width(DataWidth)) u_tx_fifo (
    .clk   (i_sclk),
    .rst   (i_reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (tx_wdata),
    .rdata (tx_rdata),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign bus.o_pe_data_ready  = !tx_full;
  assign bus.o_noc_data_valid = !tx_empty;
  assign bus.o_noc_data       = tx_rdata;

  // RX: every accepted flit is consumed; only our own address enters the buffer.
  assign rx_accept = bus.i_noc_data_valid && !rx_full;
  assign rx_hit    = (flit_dest(bus.i_noc_data) == AddrWidth'(MyAddr));
  assign rx_push   = rx_accept && rx_hit;
  assign rx_pop    = bus.i_pe_data_ready && !rx_empty;
  assign rx_wdata  = flit_payload(bus.i_noc_data);

  noc_sync_fifo #(.Depth(RxDepth), .Width(PayloadWidth)) u_rx_fifo (
    .clk   (i_sclk),
    .rst   (i_reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_wdata),
    .rdata (rx_rdata),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign bus.o_noc_data_ready = !rx_full;
  assign bus.o_pe_src_valid   = !rx_empty;
  assign bus.o_pe_data        = rx_rdata;

  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      misroute <= 1'b0;
    end else begin
      misroute <= rx_accept && !rx_hit;
    end
  end

  assign bus.o_misroute = misroute;
  assign unused_ok      = ^{tx_count, rx_count};

`ifdef NOC_LEAF_IF_STATS_EN
  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      o_tx_count   <= '0;
      o_rx_count   <= '0;
      o_drop_count <= '0;
    end else begin
      o_tx_count   <= stat_inc(o_tx_count, tx_pop);
      o_rx_count   <= stat_inc(o_rx_count, rx_pop);
      o_drop_count <= stat_inc(o_drop_count, rx_accept && !rx_hit);
    end
  end
`endif

endmodule

// File: tb/tb_noc_leaf_if.sv
// Bench for noc_leaf_if: queue-based reference model checked every cycle plus directed literal checks.
module tb_noc_leaf_if;
  localparam int unsigned DW      = 34;
  localparam int unsigned AW      = 2;
  localparam int unsigned PW      = DW - AW;
  localparam int unsigned TX_DEPTH = 4;
  localparam int unsigned MY_ADDR = 0;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  noc_leaf_bus #(.DataWidth(DW), .AddrWidth(AW)) bus ();

`ifdef NOC_LEAF_IF_STATS_EN
  logic [15:0] tx_cnt, rx_cnt, drop_cnt;
`endif

  noc_leaf_if #(.DataWidth(DW), .AddrWidth(AW), .MyAddr(MY_ADDR), .TxDepth(TX_DEPTH)) dut (
    .i_sclk  (clk),
    .i_reset (rst),
    .bus     (bus)
`ifdef NOC_LEAF_IF_STATS_EN
    ,
    .o_tx_count   (tx_cnt),
    .o_rx_count   (rx_cnt),
    .o_drop_count (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain queues, updated at each falling edge to predict the next rising edge.
  logic [DW-1:0] tx_q[$];
  logic [PW-1:0] rx_q[$];
  bit            mis_exp;
  bit            synced;
  bit            tx_fire, rx_fire;
  int unsigned   m_tx, m_rx, m_drop;

  always @(negedge clk) begin
    bit tx_pop, rx_pop, acc;
    if (synced) begin
      chk("noc_valid", 64'(bus.o_noc_data_valid), 64'(tx_q.size() != 0));
      chk("pe_ready", 64'(bus.o_pe_data_ready), 64'(tx_q.size() != TX_DEPTH));
      chk("src_valid", 64'(bus.o_pe_src_valid), 64'(rx_q.size() != 0));
      chk("noc_ready", 64'(bus.o_noc_data_ready), 64'(rx_q.size() != 2));
      chk("misroute", 64'(bus.o_misroute), 64'(mis_exp));
      if (tx_q.size() != 0) chk("noc_data", 64'(bus.o_noc_data), 64'(tx_q[0]));
      if (rx_q.size() != 0) chk("pe_data", 64'(bus.o_pe_data), 64'(rx_q[0]));
`ifdef NOC_LEAF_IF_STATS_EN
      chk("tx_count", 64'(tx_cnt), 64'(m_tx));
      chk("rx_count", 64'(rx_cnt), 64'(m_rx));
      chk("drop_count", 64'(drop_cnt), 64'(m_drop));
`endif
    end
    if (rst) begin
      tx_q.delete();
      rx_q.delete();
      mis_exp = 0;
      tx_fire = 0;
      rx_fire = 0;
      m_tx = 0; m_rx = 0; m_drop = 0;
      synced = 1;
    end else begin
      tx_fire = bus.i_pe_data_valid && (tx_q.size() < TX_DEPTH);
      tx_pop  = bus.i_noc_data_ready && (tx_q.size() > 0);
      acc     = bus.i_noc_data_valid && (rx_q.size() < 2);
      rx_fire = acc;
      rx_pop  = bus.i_pe_data_ready && (rx_q.size() > 0);
      if (tx_pop) begin void'(tx_q.pop_front()); m_tx++; end
      if (tx_fire) tx_q.push_back({bus.i_pe_dest, bus.i_pe_data});
      if (rx_pop) begin void'(rx_q.pop_front()); m_rx++; end
      mis_exp = acc && (bus.i_noc_data[DW-1:PW] != AW'(MY_ADDR));
      if (acc && !mis_exp) rx_q.push_back(bus.i_noc_data[PW-1:0]);
      if (mis_exp) m_drop++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; synced = 0;
    rst = 1'b1;
    bus.i_pe_data = '0; bus.i_pe_dest = '0; bus.i_pe_data_valid = 1'b0;
    bus.i_pe_data_ready = 1'b0; bus.i_noc_data_ready = 1'b0;
    bus.i_noc_data = '0; bus.i_noc_data_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    at_neg();
    chk("rst_noc_valid", 64'(bus.o_noc_data_valid), 64'd0);
    chk("rst_src_valid", 64'(bus.o_pe_src_valid), 64'd0);
    chk("rst_pe_ready", 64'(bus.o_pe_data_ready), 64'd1);
    chk("rst_noc_ready", 64'(bus.o_noc_data_ready), 64'd1);
    chk("rst_misroute", 64'(bus.o_misroute), 64'd0);
    chk("rst_noc_data", 64'(bus.o_noc_data), 64'd0);
    chk("rst_pe_data", 64'(bus.o_pe_data), 64'd0);

    // Single TX flit, destination 2.
    bus.i_noc_data_ready = 1'b1;
    bus.i_pe_data = 32'hDEADBEEF; bus.i_pe_dest = 2'd2; bus.i_pe_data_valid = 1'b1;
    step();
    bus.i_pe_data_valid = 1'b0;
    at_neg();
    chk("t1_valid", 64'(bus.o_noc_data_valid), 64'd1);
    chk("t1_data", 64'(bus.o_noc_data), 64'h2_DEADBEEF);
    step(); at_neg();
    chk("t1_valid_off", 64'(bus.o_noc_data_valid), 64'd0);

    // Fill TX FIFO with switch back-pressure, fifth flit waits.
    bus.i_noc_data_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_pe_data = PW'(100 + i); bus.i_pe_dest = 2'd1; bus.i_pe_data_valid = 1'b1;
      step();
    end
    bus.i_pe_data = PW'(104);
    at_neg();
    chk("t2_full", 64'(bus.o_pe_data_ready), 64'd0);
    chk("t2_head0", 64'(bus.o_noc_data), {30'd0, 2'd1, 32'd100});
    bus.i_noc_data_ready = 1'b1;
    step(); at_neg();
    chk("t2_ready_back", 64'(bus.o_pe_data_ready), 64'd1);
    chk("t2_head1", 64'(bus.o_noc_data), {30'd0, 2'd1, 32'd101});
    step();
    bus.i_pe_data_valid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      at_neg();
      chk("t2_order", 64'(bus.o_noc_data), {30'd0, 2'd1, 32'(100 + i)});
      step();
    end
    at_neg();
    chk("t2_drained", 64'(bus.o_noc_data_valid), 64'd0);

    // RX flit addressed to this leaf.
    bus.i_pe_data_ready = 1'b1;
    bus.i_noc_data = {2'b00, 32'h12345678}; bus.i_noc_data_valid = 1'b1;
    step();
    bus.i_noc_data_valid = 1'b0;
    at_neg();
    chk("t3_src_valid", 64'(bus.o_pe_src_valid), 64'd1);
    chk("t3_data", 64'(bus.o_pe_data), 64'h12345678);
    chk("t3_misroute", 64'(bus.o_misroute), 64'd0);
    step(); at_neg();
    chk("t3_src_off", 64'(bus.o_pe_src_valid), 64'd0);

    // Foreign destination is dropped with a one-cycle pulse.
    bus.i_noc_data = {2'b11, 32'hCAFEF00D}; bus.i_noc_data_valid = 1'b1;
    step();
    bus.i_noc_data_valid = 1'b0;
    at_neg();
    chk("t4_misroute", 64'(bus.o_misroute), 64'd1);
    chk("t4_src_valid", 64'(bus.o_pe_src_valid), 64'd0);
`ifdef NOC_LEAF_IF_STATS_EN
    chk("t4_drop_count", 64'(drop_cnt), 64'd1);
`endif
    step(); at_neg();
    chk("t4_misroute_off", 64'(bus.o_misroute), 64'd0);

    // RX buffer fills with PE stalled; third flit waits upstream.
    bus.i_pe_data_ready = 1'b0;
    bus.i_noc_data = {2'b00, 32'h11111111}; bus.i_noc_data_valid = 1'b1;
    step();
    bus.i_noc_data = {2'b00, 32'h22222222};
    step();
    bus.i_noc_data = {2'b00, 32'h33333333};
    at_neg();
    chk("t5_full", 64'(bus.o_noc_data_ready), 64'd0);
    chk("t5_head", 64'(bus.o_pe_data), 64'h11111111);
    step();
    bus.i_pe_data_ready = 1'b1;
    step(); at_neg();
    chk("t5_head2", 64'(bus.o_pe_data), 64'h22222222);
    chk("t5_ready_back", 64'(bus.o_noc_data_ready), 64'd1);
    step();
    bus.i_noc_data_valid = 1'b0;
    at_neg();
    chk("t5_third", 64'(bus.o_pe_data), 64'h33333333);
    chk("t5_third_valid", 64'(bus.o_pe_src_valid), 64'd1);
    step(); at_neg();
    chk("t5_empty", 64'(bus.o_pe_src_valid), 64'd0);

    // Reset with 3 TX entries and 1 RX entry buffered.
    bus.i_noc_data_ready = 1'b0; bus.i_pe_data_ready = 1'b0;
    bus.i_pe_data = PW'(200); bus.i_pe_dest = 2'd3; bus.i_pe_data_valid = 1'b1;
    bus.i_noc_data = {2'b00, 32'h44444444}; bus.i_noc_data_valid = 1'b1;
    step();
    bus.i_noc_data_valid = 1'b0;
    bus.i_pe_data = PW'(201); step();
    bus.i_pe_data = PW'(202); step();
    bus.i_pe_data_valid = 1'b0;
    at_neg();
    chk("t6_pre_src", 64'(bus.o_pe_src_valid), 64'd1);
    chk("t6_pre_tx", 64'(bus.o_noc_data_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    at_neg();
    chk("t6_noc_valid", 64'(bus.o_noc_data_valid), 64'd0);
    chk("t6_src_valid", 64'(bus.o_pe_src_valid), 64'd0);
    chk("t6_pe_ready", 64'(bus.o_pe_data_ready), 64'd1);
    chk("t6_noc_ready", 64'(bus.o_noc_data_ready), 64'd1);
    bus.i_noc_data_ready = 1'b1; bus.i_pe_data_ready = 1'b1;
    step(); step(); step(); at_neg();
    chk("t6_no_stale_tx", 64'(bus.o_noc_data_valid), 64'd0);
    chk("t6_no_stale_rx", 64'(bus.o_pe_src_valid), 64'd0);

    // Randomized traffic; producers hold valid/data until the model sees a transfer.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      if (!bus.i_pe_data_valid || tx_fire) begin
        bus.i_pe_data_valid = ($urandom_range(0, 2) != 0);
        bus.i_pe_data       = $urandom;
        bus.i_pe_dest       = AW'($urandom_range(0, 3));
      end
      if (!bus.i_noc_data_valid || rx_fire) begin
        bus.i_noc_data_valid = ($urandom_range(0, 2) != 0);
        bus.i_noc_data[PW-1:0] = $urandom;
        bus.i_noc_data[DW-1:PW] = ($urandom_range(0, 1) != 0) ? AW'(MY_ADDR)
                                                               : AW'($urandom_range(0, 3));
      end
      bus.i_noc_data_ready = ($urandom_range(0, 3) != 0);
      bus.i_pe_data_ready  = ($urandom_range(0, 3) != 0);
    end
    rst = 1'b0;
    bus.i_pe_data_valid = 1'b0; bus.i_noc_data_valid = 1'b0;
    bus.i_noc_data_ready = 1'b1; bus.i_pe_data_ready = 1'b1;
    repeat (8) step();
    at_neg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
